// File: rtl/otter_muldiv.sv
// -----------------------------------------------------------------------------
// otter_muldiv
//
// Iterative RV32M multiply/divide unit. Operands come straight from the
// register-file read ports. A 32-iteration shift-add multiply or restoring
// divide produces a 32-bit result for the write-back path.
//
// Signed operands are reduced to magnitudes when the request is accepted. The
// core then works unsigned, and the sign is re-applied on the completion edge.
// Divide-by-zero and signed overflow are resolved when the request is accepted
// and skip the iteration phase entirely.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : request, accepted in IDLE or DONE
//   funct3  : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM,    111 REMU
//   op_a    : rs1 operand (multiplicand / dividend)
//   op_b    : rs2 operand (multiplier / divisor)
//   busy    : high while iterating (registered)
//   done    : one-cycle pulse, result valid (registered)
//   result  : result, held until the next completion or reset
//
// Only XLEN = 32 is supported.
// -----------------------------------------------------------------------------
module otter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic [2:0]  funct3_q;
    logic        neg_q;        // final result must be negated
    logic [31:0] operand_q;    // multiplicand (mul) or divisor (div) magnitude
    logic [63:0] acc_q;        // mul: {partial product, multiplier}; div: quotient in [31:0]
    logic [32:0] rem_q;        // partial remainder for divide
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;

    // ------------------------------------------------------------------
    // Request decode: operand signedness, magnitudes, special cases
    // ------------------------------------------------------------------
    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic        res_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] special_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010: a_signed = 1'b1;
            default: ;
        endcase

        a_neg = a_signed & op_a[31];
        b_neg = b_signed & op_b[31];
        a_mag = a_neg ? (32'd0 - op_a) : op_a;
        b_mag = b_neg ? (32'd0 - op_b) : op_b;

        // Remainder follows the dividend; everything else follows a^b.
        // Unsigned ops have both neg flags clear, so this yields 0 for them.
        res_neg = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);

        div_zero = funct3[2] && (op_b == 32'd0);
        // Only the signed variants (DIV=100, REM=110) can overflow.
        div_ovf  = funct3[2] && !funct3[0] &&
                   (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

        special_res = 32'd0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of multiply / divide, plus final sign correction
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] prod_step;
    logic [33:0] div_shift;
    logic [33:0] div_trial;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_res;

    always_comb begin
        // Right-shifting shift-add: add the multiplicand into the upper half
        // when the current multiplier LSB is set, then shift everything right.
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, operand_q};
        prod_step = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract,
        // keep the difference only when it did not go negative.
        div_shift = {rem_q, acc_q[31]};
        div_trial = div_shift - {2'b00, operand_q};
        rem_step  = div_trial[33] ? div_shift[32:0] : div_trial[32:0];
        quo_step  = {acc_q[30:0], ~div_trial[33]};

        prod_fix = neg_q ? (64'd0 - prod_step) : prod_step;
        quo_fix  = neg_q ? (32'd0 - quo_step) : quo_step;
        rem_fix  = neg_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];

        case (funct3_q)
            3'b000:                 final_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= 5'd0;
            funct3_q  <= 3'd0;
            neg_q     <= 1'b0;
            operand_q <= 32'd0;
            acc_q     <= 64'd0;
            rem_q     <= 33'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        funct3_q <= funct3;
                        neg_q    <= res_neg;
                        count_q  <= 5'd0;
                        rem_q    <= 33'd0;
                        if (funct3[2]) begin
                            operand_q <= b_mag;
                            acc_q     <= {32'd0, a_mag};
                        end else begin
                            operand_q <= a_mag;
                            acc_q     <= {32'd0, b_mag};
                        end
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    count_q <= count_q + 5'd1;
                    if (funct3_q[2]) begin
                        acc_q <= {acc_q[63:32], quo_step};
                        rem_q <= rem_step;
                    end else begin
                        acc_q <= prod_step;
                    end
                    if (count_q == 5'd31) begin
                        result_q <= final_res;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
